// File: rtl/mesh_router_pkg.sv
// mesh_router_pkg: direction encoding, default routing matrices and arbiter sizing helper
package mesh_router_pkg;
  typedef enum logic [2:0] {P = 3'd0, W = 3'd1, E = 3'd2, N = 3'd3, S = 3'd4} dir_e;
  // [1][in] = legal outputs of an input, [0][out] = legal inputs of an output
  localparam bit [1:0][4:0][4:0] StrictXY = '{
    '{5'b01001, 5'b10001, 5'b11011, 5'b11101, 5'b11111},
    '{5'b01111, 5'b10111, 5'b00011, 5'b00101, 5'b11111}};
  localparam bit [1:0][2:0][2:0] StrictX = '{
    '{3'b011, 3'b101, 3'b111},
    '{3'b011, 3'b101, 3'b111}};
  function automatic int popcount(input logic [31:0] v);
    int c;
    c = 0;
    for (int i = 0; i < 32; i++) c += int'(v[i]);
    return c;
  endfunction
endpackage

// File: rtl/mesh_router_rr_arb.sv
// mesh_router_rr_arb: round-robin arbiter that holds its grant while stalled
module mesh_router_rr_arb #(
  parameter int width_p = 2,
  localparam int iw = width_p > 1 ? $clog2(width_p) : 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] req_i,
  input  logic               yumi_i,
  output logic [width_p-1:0] grant_o,
  output logic               v_o
);
  logic [iw-1:0] ptr, hold_idx, rr_idx, idx;
  logic hold, rr_v;
  int j;
  always_comb begin
    rr_idx = '0;
    rr_v = 1'b0;
    j = 0;
    for (int k = width_p - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= width_p) j -= width_p;
      if (req_i[j]) begin
        rr_idx = iw'(j);
        rr_v = 1'b1;
      end
    end
  end
  assign idx = hold ? hold_idx : rr_idx;
  assign v_o = hold | rr_v;
  assign grant_o = width_p'(v_o) << idx;
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      ptr <= '0;
      hold <= 1'b0;
      hold_idx <= '0;
    end else begin
      hold <= v_o & ~yumi_i;
      hold_idx <= idx;
      if (v_o & yumi_i) ptr <= int'(idx) == width_p - 1 ? '0 : idx + 1'b1;
    end
endmodule

// File: rtl/mesh_router_rr.sv
// mesh_router_rr: buffered dimension-order mesh router with sparse round-robin output arbitration
module mesh_router_rr
  import mesh_router_pkg::*;
#(
  parameter int dims_p = 2,
  localparam int dirs_lp = dims_p * 2 + 1,
  parameter int width_p = 32,
  parameter int x_cord_width_p = 4,
  parameter int y_cord_width_p = 4,
  parameter int fifo_els_p = 2,
  parameter bit [1:0][dirs_lp-1:0][dirs_lp-1:0] routing_matrix_p = (dims_p == 2)
    ? (2*dirs_lp*dirs_lp)'(StrictXY) : (2*dirs_lp*dirs_lp)'(StrictX)
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [x_cord_width_p-1:0]        my_x_i,
  input  logic [y_cord_width_p-1:0]        my_y_i,
  input  logic [dirs_lp-1:0]               v_i,
  input  logic [dirs_lp-1:0][width_p-1:0]  data_i,
  output logic [dirs_lp-1:0]               ready_o,
  output logic [dirs_lp-1:0]               v_o,
  output logic [dirs_lp-1:0][width_p-1:0]  data_o,
  input  logic [dirs_lp-1:0]               ready_i,
  output logic [dirs_lp-1:0]               err_o
);
  localparam int aw = fifo_els_p > 1 ? $clog2(fifo_els_p) : 1;
  logic [dirs_lp-1:0][width_p-1:0] head;
  logic [dirs_lp-1:0][dirs_lp-1:0] req, take;
  logic [dirs_lp-1:0] drop, deq;
  always_comb begin
    deq = drop;
    for (int o = 0; o < dirs_lp; o++) deq |= take[o];
  end
  for (genvar i = 0; i < dirs_lp; i++) begin : g_in
    logic [width_p-1:0] mem [fifo_els_p];
    logic [aw-1:0] wa, ra;
    logic ww, rw, empty, full, enq, err;
    logic [x_cord_width_p-1:0] dx;
    logic [y_cord_width_p-1:0] dy;
    dir_e route;
    assign full = (wa == ra) && (ww != rw);
    assign empty = (wa == ra) && (ww == rw);
    assign ready_o[i] = !full;
    assign enq = v_i[i] && !full;
    assign head[i] = mem[ra];
    assign dx = head[i][x_cord_width_p-1:0];
    assign dy = head[i][x_cord_width_p +: y_cord_width_p];
    always_comb route = dx > my_x_i ? E : dx < my_x_i ? W : dims_p == 1 ? P : dy > my_y_i ? S : dy < my_y_i ? N : P;
    // a head with no legal output never requests and is discarded instead
    assign req[i] = empty ? '0 : (dirs_lp'(1) << route) & routing_matrix_p[1][i];
    assign drop[i] = !empty && !(|req[i]);
    assign err_o[i] = err;
    always_ff @(posedge clk_i) if (enq) mem[wa] <= data_i[i];
    always_ff @(posedge clk_i or posedge reset_i)
      if (reset_i) begin
        wa <= '0;
        ra <= '0;
        ww <= 1'b0;
        rw <= 1'b0;
        err <= 1'b0;
      end else begin
        if (enq) begin
          wa <= int'(wa) == fifo_els_p - 1 ? '0 : wa + 1'b1;
          ww <= ww ^ (int'(wa) == fifo_els_p - 1);
        end
        if (deq[i]) begin
          ra <= int'(ra) == fifo_els_p - 1 ? '0 : ra + 1'b1;
          rw <= rw ^ (int'(ra) == fifo_els_p - 1);
        end
        if (drop[i]) err <= 1'b1;
      end
  end
  for (genvar o = 0; o < dirs_lp; o++) begin : g_out
    localparam logic [31:0] mask = 32'(routing_matrix_p[0][o]);
    localparam int n = popcount(mask);
    logic [dirs_lp-1:0] gnt;
    logic [width_p-1:0] d;
    if (n > 0) begin : g_arb
      logic [n-1:0] areq, agnt;
      logic av;
      for (genvar i = 0; i < dirs_lp; i++) begin : g_map
        if (mask[i]) begin : g_c
          localparam int k = popcount(mask & ((32'd1 << i) - 32'd1));
          assign areq[k] = req[i][o];
          assign gnt[i] = agnt[k];
        end else begin : g_z
          assign gnt[i] = 1'b0;
        end
      end
      mesh_router_rr_arb #(.width_p(n)) arb (
        .clk_i(clk_i), .reset_i(reset_i), .req_i(areq),
        .yumi_i(av & ready_i[o]), .grant_o(agnt), .v_o(av));
    end else begin : g_none
      assign gnt = '0;
    end
    always_comb begin
      d = '0;
      for (int i = 0; i < dirs_lp; i++) d |= gnt[i] ? head[i] : '0;
    end
    assign v_o[o] = |gnt;
    assign data_o[o] = d;
    assign take[o] = ready_i[o] ? gnt : '0;
  end
endmodule

// File: tb/tb_mesh_router_rr.sv
// tb_mesh_router_rr: directed bench with a queue-level reference model of the router
module tb_mesh_router_rr;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  logic [3:0] my_x, my_y;
  logic [4:0] v_i, ready_i, ready_o, v_o, err_o;
  logic [4:0][15:0] data_i, data_o;
  logic [2:0] v1_i, ready1_i, ready1_o, v1_o, err1_o;
  logic [2:0][15:0] data1_i, data1_o;
  int n_chk = 0, n_fail = 0;

  mesh_router_rr #(.dims_p(2), .width_p(16), .x_cord_width_p(4), .y_cord_width_p(4), .fifo_els_p(2)) u0 (
    .clk_i(clk), .reset_i(rst), .my_x_i(my_x), .my_y_i(my_y), .v_i(v_i), .data_i(data_i),
    .ready_o(ready_o), .v_o(v_o), .data_o(data_o), .ready_i(ready_i), .err_o(err_o));
  mesh_router_rr #(.dims_p(1), .width_p(16), .x_cord_width_p(4), .y_cord_width_p(4), .fifo_els_p(2)) u1 (
    .clk_i(clk), .reset_i(rst), .my_x_i(my_x), .my_y_i(my_y), .v_i(v1_i), .data_i(data1_i),
    .ready_o(ready1_o), .v_o(v1_o), .data_o(data1_o), .ready_i(ready1_i), .err_o(err1_o));

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // model of the 2-D router at (1,1): per-input queues, XY turn rules, rotating priority
  logic [15:0] mq [5][2];
  int mcnt [5], mptr [5], mwin [5], ncand [5];
  int cand [5][5];
  bit mlock [5], merr [5];

  function automatic int route_of(input logic [15:0] h);
    if (h[3:0] > 4'd1) return 2;
    if (h[3:0] < 4'd1) return 1;
    if (h[7:4] > 4'd1) return 4;
    if (h[7:4] < 4'd1) return 3;
    return 0;
  endfunction
  function automatic bit legal_turn(input int in, input int out);
    if (in == 0 || out == 0) return 1'b1;
    if (in == 1) return out != 1;
    if (in == 2) return out != 2;
    if (in == 3) return out == 4;
    return out == 3;
  endfunction
  function automatic int req_of(input int i);
    int r;
    if (mcnt[i] == 0) return -2;
    r = route_of(mq[i][0]);
    return legal_turn(i, r) ? r : -1;
  endfunction
  task automatic model_reset();
    for (int i = 0; i < 5; i++) begin
      mcnt[i] = 0; mptr[i] = 0; mlock[i] = 1'b0; mwin[i] = 0; merr[i] = 1'b0;
    end
  endtask
  task automatic mpop(input int i);
    mq[i][0] = mq[i][1];
    mcnt[i]--;
  endtask

  initial begin
    for (int o = 0; o < 5; o++) begin
      ncand[o] = 0;
      for (int i = 0; i < 5; i++) if (legal_turn(i, o)) begin
        cand[o][ncand[o]] = i;
        ncand[o]++;
      end
    end
    model_reset();
  end

  always @(negedge clk) begin
    logic [4:0] ev, er, ee;
    int ew [5];
    bit enq [5], drp [5];
    int c;
    if (rst) model_reset();
    ev = '0; er = '0; ee = '0;
    for (int o = 0; o < 5; o++) begin
      ew[o] = 0;
      if (mlock[o]) begin
        ev[o] = 1'b1;
        ew[o] = mwin[o];
      end else for (int k = 0; k < ncand[o]; k++) begin
        c = cand[o][(mptr[o] + k) % ncand[o]];
        if (!ev[o] && req_of(c) == o) begin
          ev[o] = 1'b1;
          ew[o] = c;
        end
      end
    end
    for (int i = 0; i < 5; i++) begin
      er[i] = mcnt[i] < 2;
      ee[i] = merr[i];
    end
    chk("model v_o", 32'(v_o), 32'(ev));
    chk("model ready_o", 32'(ready_o), 32'(er));
    chk("model err_o", 32'(err_o), 32'(ee));
    for (int o = 0; o < 5; o++) if (ev[o]) chk($sformatf("model data_o[%0d]", o), 32'(data_o[o]), 32'(mq[ew[o]][0]));
    if (!rst) begin
      for (int i = 0; i < 5; i++) begin
        enq[i] = v_i[i] && mcnt[i] < 2;
        drp[i] = req_of(i) == -1;
      end
      for (int o = 0; o < 5; o++)
        if (ev[o] && ready_i[o]) begin
          for (int k = 0; k < ncand[o]; k++) if (cand[o][k] == ew[o]) mptr[o] = (k + 1) % ncand[o];
          mpop(ew[o]);
          mlock[o] = 1'b0;
        end else begin
          mlock[o] = ev[o];
          mwin[o] = ew[o];
        end
      for (int i = 0; i < 5; i++) if (drp[i]) begin
        mpop(i);
        merr[i] = 1'b1;
      end
      for (int i = 0; i < 5; i++) if (enq[i]) begin
        mq[i][mcnt[i]] = data_i[i];
        mcnt[i]++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cnt [5];
    rst = 1'b0;
    my_x = 4'd1; my_y = 4'd1;
    v_i = '0; data_i = '0; ready_i = '1;
    v1_i = '0; data1_i = '0; ready1_i = '1;
    #1 rst = 1'b1;
    step();
    chk("reset ready_o", 32'(ready_o), 32'h1f);
    chk("reset v_o", 32'(v_o), 32'h0);
    chk("reset err_o", 32'(err_o), 32'h0);
    chk("reset ready1_o", 32'(ready1_o), 32'h7);
    step();
    rst = 1'b0;
    step();
    // single packets from P: east, north, loopback
    v_i[0] = 1'b1; data_i[0] = 16'h1113;
    step();
    v_i[0] = 1'b0;
    chk("route E v_o", 32'(v_o), 32'h04);
    chk("route E data", 32'(data_o[2]), 32'h1113);
    step();
    v_i[0] = 1'b1; data_i[0] = 16'h2201;
    step();
    v_i[0] = 1'b0;
    chk("route N v_o", 32'(v_o), 32'h08);
    chk("route N data", 32'(data_o[3]), 32'h2201);
    step();
    v_i[0] = 1'b1; data_i[0] = 16'h3311;
    step();
    v_i[0] = 1'b0;
    chk("route P v_o", 32'(v_o), 32'h01);
    chk("route P data", 32'(data_o[0]), 32'h3311);
    step();
    // W, N, S continuously toward P
    v_i = 5'b11010;
    data_i[1] = 16'h1011; data_i[3] = 16'h3011; data_i[4] = 16'h4011;
    for (int k = 0; k < 5; k++) cnt[k] = 0;
    step();
    for (int c = 0; c < 30; c++) begin
      if (v_o[0]) cnt[data_o[0][15:12]]++;
      step();
    end
    v_i = '0;
    chk("rr count W", cnt[1], 10);
    chk("rr count N", cnt[3], 10);
    chk("rr count S", cnt[4], 10);
    repeat (8) step();
    // stalled east output with a full P FIFO
    ready_i = 5'b11011;
    v_i[0] = 1'b1; data_i[0] = 16'hA113;
    step();
    data_i[0] = 16'hB113;
    step();
    chk("full ready_o[P]", 32'(ready_o[0]), 32'h0);
    data_i[0] = 16'hC113;
    step();
    v_i[0] = 1'b0;
    chk("stall v_o[E]", 32'(v_o[2]), 32'h1);
    chk("stall data A", 32'(data_o[2]), 32'hA113);
    step(); step();
    chk("stall data held", 32'(data_o[2]), 32'hA113);
    ready_i = '1;
    step();
    chk("drain data B", 32'(data_o[2]), 32'hB113);
    step();
    chk("drain empty v_o[E]", 32'(v_o[2]), 32'h0);
    step();
    // reset with the P FIFO full
    ready_i = 5'b11011;
    v_i[0] = 1'b1; data_i[0] = 16'hD113;
    step();
    data_i[0] = 16'hE113;
    step();
    v_i[0] = 1'b0;
    chk("prefill ready_o[P]", 32'(ready_o[0]), 32'h0);
    rst = 1'b1;
    #1;
    chk("async reset ready_o", 32'(ready_o), 32'h1f);
    chk("async reset v_o", 32'(v_o), 32'h0);
    step();
    rst = 1'b0;
    ready_i = '1;
    step();
    chk("post reset v_o", 32'(v_o), 32'h0);
    chk("post reset ready_o", 32'(ready_o), 32'h1f);
    // illegal turn N input -> E
    v_i[3] = 1'b1; data_i[3] = 16'h5513;
    step();
    v_i[3] = 1'b0;
    chk("illegal no v_o[E]", 32'(v_o[2]), 32'h0);
    chk("illegal err before drop", 32'(err_o), 32'h0);
    step();
    chk("illegal err_o", 32'(err_o), 32'h08);
    step(); step();
    chk("illegal err sticky", 32'(err_o), 32'h08);
    chk("illegal v_o idle", 32'(v_o), 32'h0);
    // 1-D router
    v1_i[0] = 1'b1; data1_i[0] = 16'h6670;
    step();
    v1_i[0] = 1'b0;
    chk("1d route W v_o", 32'(v1_o), 32'h2);
    chk("1d route W data", 32'(data1_o[1]), 32'h6670);
    step();
    v1_i[0] = 1'b1; data1_i[0] = 16'h7771;
    step();
    v1_i[0] = 1'b0;
    chk("1d ignore Y v_o", 32'(v1_o), 32'h1);
    chk("1d ignore Y data", 32'(data1_o[0]), 32'h7771);
    step();
    v1_i = 3'b111;
    data1_i[0] = 16'h0011; data1_i[1] = 16'h1011; data1_i[2] = 16'h2011;
    for (int k = 0; k < 5; k++) cnt[k] = 0;
    step();
    for (int c = 0; c < 9; c++) begin
      if (v1_o[0]) cnt[data1_o[0][15:12]]++;
      step();
    end
    v1_i = '0;
    chk("1d rr count P", cnt[0], 3);
    chk("1d rr count W", cnt[1], 3);
    chk("1d rr count E", cnt[2], 3);
    repeat (8) step();
    chk("1d err_o", 32'(err1_o), 32'h0);
    chk("1d idle v_o", 32'(v1_o), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
